// File: rtl/datapath_hs.sv
// rtl/datapath_hs.sv - parametrised accumulator datapath (PC/MAR/MBR/IR/ACC, 8-op ALU) with req/ready memory port
module datapath_hs #(
  parameter int DATA_W = 16,
  parameter int ADDR_W = 8,
  parameter int OPC_W  = 8
) (
  input  logic              i_clk,
  input  logic              i_rst_n,
  input  logic [15:0]       i_ctrl,
  input  logic [3:0]        i_alu_op,
  input  logic              i_ctrl_mar_increment,
  input  logic              i_ctrl_pc_increment,
  input  logic              i_ctrl_halt,
  output logic              o_mem_req,
  output logic              o_mem_we,
  output logic [ADDR_W-1:0] o_mem_addr,
  output logic [DATA_W-1:0] o_mem_wdata,
  input  logic [DATA_W-1:0] i_mem_rdata,
  input  logic              i_mem_ready,
  output logic              o_busy,
  output logic [OPC_W-1:0]  o_ir_cu,
  output logic [4:0]        o_flags
);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_READ  = 2'd1,
    ST_WRITE = 2'd2
  } mem_state_e;

  localparam logic [2:0] OP_ADD = 3'd0;
  localparam logic [2:0] OP_SUB = 3'd1;
  localparam logic [2:0] OP_AND = 3'd2;
  localparam logic [2:0] OP_OR  = 3'd3;
  localparam logic [2:0] OP_MUL = 3'd4;
  localparam logic [2:0] OP_NOT = 3'd5;
  localparam logic [2:0] OP_SHL = 3'd6;
  localparam logic [2:0] OP_SHR = 3'd7;

  localparam logic [ADDR_W-1:0] ADDR_ONE = {{(ADDR_W-1){1'b0}}, 1'b1};
  localparam int EXT_W = DATA_W - ADDR_W;

  mem_state_e        state_q, state_d;
  logic [ADDR_W-1:0] pc_q, pc_d;
  logic [ADDR_W-1:0] mar_q, mar_d;
  logic [DATA_W-1:0] mbr_q, mbr_d;
  logic [DATA_W-1:0] ir_q, ir_d;
  logic [DATA_W-1:0] acc_q, acc_d;
  logic [DATA_W-1:0] br_q, br_d;
  logic [DATA_W-1:0] mr_q, mr_d;
  logic [4:0]        flags_q, flags_d;
  logic [OPC_W-1:0]  ir_cu_q, ir_cu_d;

  // C0 (address select) and C6/C7 (operand selects) are hard-wired in this datapath
  logic ctrl_unused;
  assign ctrl_unused = ^{i_ctrl[0], i_ctrl[7:6]};

  logic                idle;
  logic [DATA_W:0]     add_w;
  logic [DATA_W:0]     sub_w;
  logic [2*DATA_W-1:0] mul_w;
  logic [DATA_W-1:0]   alu_res;
  logic [DATA_W-1:0]   alu_hi;
  logic                alu_c;
  logic                alu_v;
  logic                p_msb;
  logic                q_msb;

  assign idle  = (state_q == ST_IDLE);
  assign p_msb = acc_q[DATA_W-1];
  assign q_msb = mbr_q[DATA_W-1];
  assign add_w = {1'b0, acc_q} + {1'b0, mbr_q};
  assign sub_w = {1'b0, acc_q} - {1'b0, mbr_q};
  assign mul_w = {{DATA_W{1'b0}}, acc_q} * {{DATA_W{1'b0}}, mbr_q};

  // ALU: P = ACC, Q = MBR; the top bit of sub_w is the borrow
  always_comb begin
    alu_res = '0;
    alu_hi  = '0;
    alu_c   = 1'b0;
    alu_v   = 1'b0;
    case (i_alu_op[2:0])
      OP_ADD: begin
        alu_res = add_w[DATA_W-1:0];
        alu_c   = add_w[DATA_W];
        alu_v   = (p_msb == q_msb) && (add_w[DATA_W-1] != p_msb);
      end
      OP_SUB: begin
        alu_res = sub_w[DATA_W-1:0];
        alu_c   = sub_w[DATA_W];
        alu_v   = (p_msb != q_msb) && (sub_w[DATA_W-1] != p_msb);
      end
      OP_AND: alu_res = acc_q & mbr_q;
      OP_OR:  alu_res = acc_q | mbr_q;
      OP_MUL: begin
        alu_res = mul_w[DATA_W-1:0];
        alu_hi  = mul_w[2*DATA_W-1:DATA_W];
      end
      OP_NOT: alu_res = ~acc_q;
      OP_SHL: begin
        alu_res = {acc_q[DATA_W-2:0], 1'b0};
        alu_c   = acc_q[DATA_W-1];
      end
      OP_SHR: begin
        alu_res = {1'b0, acc_q[DATA_W-1:1]};
        alu_c   = acc_q[0];
      end
      default: alu_res = '0;
    endcase
  end

  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    mar_d   = mar_q;
    mbr_d   = mbr_q;
    ir_d    = ir_q;
    acc_d   = acc_q;
    br_d    = br_q;
    mr_d    = mr_q;
    flags_d = flags_q;
    ir_cu_d = ir_cu_q;

    case (state_q)
      ST_IDLE: begin
        if (i_ctrl[5]) begin
          state_d = ST_READ;
        end else if (i_ctrl[13]) begin
          state_d = ST_WRITE;
        end
      end
      ST_READ: begin
        if (i_mem_ready) begin
          mbr_d   = i_mem_rdata;
          state_d = ST_IDLE;
        end
      end
      ST_WRITE: begin
        if (i_mem_ready) begin
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase

    // Control-word transfers only while idle, so MAR/MBR stay stable under a transaction
    if (idle) begin
      if (i_ctrl[3]) begin
        pc_d = mbr_q[ADDR_W-1:0];
      end else if (i_ctrl_pc_increment) begin
        pc_d = pc_q + ADDR_ONE;
      end

      if (i_ctrl[8]) begin
        mar_d = mbr_q[ADDR_W-1:0];
      end else if (i_ctrl[2]) begin
        mar_d = pc_q;
      end else if (i_ctrl_mar_increment) begin
        mar_d = mar_q + ADDR_ONE;
      end

      if (i_ctrl[12]) begin
        mbr_d = acc_q;
      end else if (i_ctrl[1]) begin
        mbr_d = {{EXT_W{1'b0}}, pc_q};
      end else if (i_ctrl[15]) begin
        mbr_d = {{EXT_W{1'b0}}, ir_q[ADDR_W-1:0]};
      end

      if (i_ctrl[11]) begin
        acc_d = mbr_q;
      end else if (i_ctrl[10]) begin
        acc_d = mr_q;
      end else if (i_ctrl[9]) begin
        acc_d = br_q;
      end

      if (i_ctrl[4]) begin
        ir_d = mbr_q;
      end
      if (i_ctrl[14]) begin
        ir_cu_d = ir_q[DATA_W-1 -: OPC_W];
      end

      if (i_alu_op[3]) begin
        br_d    = alu_res;
        mr_d    = alu_hi;
        flags_d = {(alu_hi != '0), alu_v, alu_c, alu_res[DATA_W-1], (alu_res == '0)};
      end
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q <= ST_IDLE;
      pc_q    <= '0;
      mar_q   <= '0;
      mbr_q   <= '0;
      ir_q    <= '0;
      acc_q   <= '0;
      br_q    <= '0;
      mr_q    <= '0;
      flags_q <= '0;
      ir_cu_q <= '0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      mar_q   <= mar_d;
      mbr_q   <= mbr_d;
      ir_q    <= ir_d;
      acc_q   <= acc_d;
      br_q    <= br_d;
      mr_q    <= mr_d;
      flags_q <= flags_d;
      ir_cu_q <= ir_cu_d;
    end
  end

  assign o_busy      = (state_q != ST_IDLE);
  assign o_mem_req   = (state_q != ST_IDLE);
  assign o_mem_we    = (state_q == ST_WRITE);
  assign o_mem_addr  = mar_q;
  assign o_mem_wdata = mbr_q;
  assign o_flags     = flags_q;
  // Halt masks the opcode combinationally without disturbing the latch
  assign o_ir_cu     = i_ctrl_halt ? '0 : ir_cu_q;

endmodule

// File: tb/tb_datapath_hs.sv
// tb/tb_datapath_hs.sv - directed vector bench for datapath_hs
module tb_datapath_hs;

  localparam logic [15:0] C1  = 16'h0002;
  localparam logic [15:0] C2  = 16'h0004;
  localparam logic [15:0] C3  = 16'h0008;
  localparam logic [15:0] C4  = 16'h0010;
  localparam logic [15:0] C5  = 16'h0020;
  localparam logic [15:0] C8  = 16'h0100;
  localparam logic [15:0] C9  = 16'h0200;
  localparam logic [15:0] C10 = 16'h0400;
  localparam logic [15:0] C11 = 16'h0800;
  localparam logic [15:0] C12 = 16'h1000;
  localparam logic [15:0] C13 = 16'h2000;
  localparam logic [15:0] C14 = 16'h4000;
  localparam logic [15:0] C15 = 16'h8000;

  localparam logic [3:0] NOP = 4'h0;
  localparam logic [3:0] ADD = 4'h8;
  localparam logic [3:0] SUB = 4'h9;
  localparam logic [3:0] AND = 4'hA;
  localparam logic [3:0] OR  = 4'hB;
  localparam logic [3:0] MUL = 4'hC;
  localparam logic [3:0] NOT = 4'hD;
  localparam logic [3:0] SHL = 4'hE;
  localparam logic [3:0] SHR = 4'hF;

  logic        clk;
  logic        rst_n;
  logic [15:0] ctrl;
  logic [3:0]  alu_op;
  logic        mar_inc;
  logic        pc_inc;
  logic        halt;
  logic        mem_req;
  logic        mem_we;
  logic [7:0]  mem_addr;
  logic [15:0] mem_wdata;
  logic [15:0] mem_rdata;
  logic        mem_ready;
  logic        busy;
  logic [7:0]  ir_cu;
  logic [4:0]  flags;

  int checks   = 0;
  int failures = 0;

  datapath_hs dut (
    .i_clk                (clk),
    .i_rst_n              (rst_n),
    .i_ctrl               (ctrl),
    .i_alu_op             (alu_op),
    .i_ctrl_mar_increment (mar_inc),
    .i_ctrl_pc_increment  (pc_inc),
    .i_ctrl_halt          (halt),
    .o_mem_req            (mem_req),
    .o_mem_we             (mem_we),
    .o_mem_addr           (mem_addr),
    .o_mem_wdata          (mem_wdata),
    .i_mem_rdata          (mem_rdata),
    .i_mem_ready          (mem_ready),
    .o_busy               (busy),
    .o_ir_cu              (ir_cu),
    .o_flags              (flags)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct packed {
    logic [15:0] ctrl;
    logic [3:0]  alu;
    logic        mi;
    logic        pi;
    logic        halt;
    logic        rdy;
    logic [15:0] rdata;
    logic        req;
    logic        we;
    logic [7:0]  addr;
    logic [15:0] wdata;
    logic        busy;
    logic [7:0]  ir;
    logic [4:0]  fl;
  } vec_t;

  vec_t vecs[$];

  function automatic vec_t v(input logic [15:0] c, input logic [3:0] a, input logic mi, input logic pi,
                             input logic h, input logic r, input logic [15:0] rd, input logic rq,
                             input logic w, input logic [7:0] ad, input logic [15:0] wd, input logic b,
                             input logic [7:0] ir, input logic [4:0] fl);
    vec_t t;
    t = '{ctrl: c, alu: a, mi: mi, pi: pi, halt: h, rdy: r, rdata: rd,
          req: rq, we: w, addr: ad, wdata: wd, busy: b, ir: ir, fl: fl};
    return t;
  endfunction

  task automatic drive(input logic [15:0] c, input logic [3:0] a, input logic mi, input logic pi,
                       input logic h, input logic r, input logic [15:0] rd);
    ctrl      = c;
    alu_op    = a;
    mar_inc   = mi;
    pc_inc    = pi;
    halt      = h;
    mem_ready = r;
    mem_rdata = rd;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic expect_out(input string name, input logic rq, input logic w, input logic [7:0] ad,
                            input logic [15:0] wd, input logic b, input logic [7:0] ir, input logic [4:0] fl);
    checks++;
    if ({mem_req, mem_we, mem_addr, mem_wdata, busy, ir_cu, flags} !== {rq, w, ad, wd, b, ir, fl}) begin
      failures++;
      $display("FAIL %s: got req=%0b we=%0b addr=%02h wdata=%04h busy=%0b ir=%02h flags=%02h, want req=%0b we=%0b addr=%02h wdata=%04h busy=%0b ir=%02h flags=%02h",
               name, mem_req, mem_we, mem_addr, mem_wdata, busy, ir_cu, flags, rq, w, ad, wd, b, ir, fl);
    end
  endtask

  initial begin
    for (int i = 0; i < 5; i++) vecs.push_back(v(0, NOP, 0, 1, 0, 0, 16'h0, 0, 0, 8'h00, 16'h0000, 0, 8'h00, 5'h00));
    vecs.push_back(v(C1|C2, NOP, 0, 0, 0, 0, 16'h0,         0, 0, 8'h05, 16'h0005, 0, 8'h00, 5'h00));
    vecs.push_back(v(C5, NOP, 0, 0, 0, 0, 16'h0,            1, 0, 8'h05, 16'h0005, 1, 8'h00, 5'h00));
    vecs.push_back(v(0, NOP, 0, 0, 0, 0, 16'h0,             1, 0, 8'h05, 16'h0005, 1, 8'h00, 5'h00));
    vecs.push_back(v(C12|C2|C8|C3, NOT, 1, 1, 0, 0, 16'h0,  1, 0, 8'h05, 16'h0005, 1, 8'h00, 5'h00));
    vecs.push_back(v(0, NOP, 0, 0, 0, 0, 16'h0,             1, 0, 8'h05, 16'h0005, 1, 8'h00, 5'h00));
    vecs.push_back(v(0, NOP, 0, 0, 0, 1, 16'hA3C1,          0, 0, 8'h05, 16'hA3C1, 0, 8'h00, 5'h00));
    vecs.push_back(v(C4, NOP, 0, 0, 0, 0, 16'h0,            0, 0, 8'h05, 16'hA3C1, 0, 8'h00, 5'h00));
    vecs.push_back(v(C14, NOP, 0, 0, 0, 0, 16'h0,           0, 0, 8'h05, 16'hA3C1, 0, 8'hA3, 5'h00));
    vecs.push_back(v(0, NOP, 0, 0, 1, 0, 16'h0,             0, 0, 8'h05, 16'hA3C1, 0, 8'h00, 5'h00));
    vecs.push_back(v(C15, NOP, 0, 0, 0, 0, 16'h0,           0, 0, 8'h05, 16'h00C1, 0, 8'hA3, 5'h00));
    vecs.push_back(v(C5, NOP, 0, 0, 0, 0, 16'h0,            1, 0, 8'h05, 16'h00C1, 1, 8'hA3, 5'h00));
    vecs.push_back(v(0, NOP, 0, 0, 0, 1, 16'h7FFF,          0, 0, 8'h05, 16'h7FFF, 0, 8'hA3, 5'h00));
    vecs.push_back(v(C11, NOP, 0, 0, 0, 1, 16'h1111,        0, 0, 8'h05, 16'h7FFF, 0, 8'hA3, 5'h00));
    vecs.push_back(v(C5, NOP, 0, 0, 0, 1, 16'h2222,         1, 0, 8'h05, 16'h7FFF, 1, 8'hA3, 5'h00));
    vecs.push_back(v(0, NOP, 0, 0, 0, 1, 16'h0001,          0, 0, 8'h05, 16'h0001, 0, 8'hA3, 5'h00));
    vecs.push_back(v(0, ADD, 0, 0, 0, 0, 16'h0,             0, 0, 8'h05, 16'h0001, 0, 8'hA3, 5'h0A));
    vecs.push_back(v(C9, NOP, 0, 0, 0, 0, 16'h0,            0, 0, 8'h05, 16'h0001, 0, 8'hA3, 5'h0A));
    vecs.push_back(v(C12, NOP, 0, 0, 0, 0, 16'h0,           0, 0, 8'h05, 16'h8000, 0, 8'hA3, 5'h0A));
    vecs.push_back(v(0, SUB, 0, 0, 0, 0, 16'h0,             0, 0, 8'h05, 16'h8000, 0, 8'hA3, 5'h01));
    vecs.push_back(v(C11, SHL, 0, 0, 0, 0, 16'h0,           0, 0, 8'h05, 16'h8000, 0, 8'hA3, 5'h05));
    vecs.push_back(v(0, SHR, 0, 0, 0, 0, 16'h0,             0, 0, 8'h05, 16'h8000, 0, 8'hA3, 5'h00));
    vecs.push_back(v(C9, NOP, 0, 0, 0, 0, 16'h0,            0, 0, 8'h05, 16'h8000, 0, 8'hA3, 5'h00));
    vecs.push_back(v(C12, NOP, 0, 0, 0, 0, 16'h0,           0, 0, 8'h05, 16'h4000, 0, 8'hA3, 5'h00));
    vecs.push_back(v(C5, NOP, 0, 0, 0, 0, 16'h0,            1, 0, 8'h05, 16'h4000, 1, 8'hA3, 5'h00));
    vecs.push_back(v(0, NOP, 0, 0, 0, 1, 16'h1234,          0, 0, 8'h05, 16'h1234, 0, 8'hA3, 5'h00));
    vecs.push_back(v(C11, NOP, 0, 0, 0, 0, 16'h0,           0, 0, 8'h05, 16'h1234, 0, 8'hA3, 5'h00));
    vecs.push_back(v(C5, NOP, 0, 0, 0, 0, 16'h0,            1, 0, 8'h05, 16'h1234, 1, 8'hA3, 5'h00));
    vecs.push_back(v(0, NOP, 0, 0, 0, 1, 16'h0100,          0, 0, 8'h05, 16'h0100, 0, 8'hA3, 5'h00));
    vecs.push_back(v(0, MUL, 0, 0, 0, 0, 16'h0,             0, 0, 8'h05, 16'h0100, 0, 8'hA3, 5'h10));
    vecs.push_back(v(C10, NOP, 0, 0, 0, 0, 16'h0,           0, 0, 8'h05, 16'h0100, 0, 8'hA3, 5'h10));
    vecs.push_back(v(C12, NOP, 0, 0, 0, 0, 16'h0,           0, 0, 8'h05, 16'h0012, 0, 8'hA3, 5'h10));
    vecs.push_back(v(0, AND, 0, 0, 0, 0, 16'h0,             0, 0, 8'h05, 16'h0012, 0, 8'hA3, 5'h00));
    vecs.push_back(v(C10, NOP, 0, 0, 0, 0, 16'h0,           0, 0, 8'h05, 16'h0012, 0, 8'hA3, 5'h00));
    vecs.push_back(v(C12, NOP, 0, 0, 0, 0, 16'h0,           0, 0, 8'h05, 16'h0000, 0, 8'hA3, 5'h00));
    vecs.push_back(v(0, NOT, 0, 0, 0, 0, 16'h0,             0, 0, 8'h05, 16'h0000, 0, 8'hA3, 5'h02));
    vecs.push_back(v(C9, NOP, 0, 0, 0, 0, 16'h0,            0, 0, 8'h05, 16'h0000, 0, 8'hA3, 5'h02));
    vecs.push_back(v(C12, NOP, 0, 0, 0, 0, 16'h0,           0, 0, 8'h05, 16'hFFFF, 0, 8'hA3, 5'h02));
    vecs.push_back(v(C1, NOP, 0, 0, 0, 0, 16'h0,            0, 0, 8'h05, 16'h0005, 0, 8'hA3, 5'h02));
    vecs.push_back(v(0, ADD, 0, 0, 0, 0, 16'h0,             0, 0, 8'h05, 16'h0005, 0, 8'hA3, 5'h04));
    vecs.push_back(v(0, SUB, 0, 0, 0, 0, 16'h0,             0, 0, 8'h05, 16'h0005, 0, 8'hA3, 5'h02));
    vecs.push_back(v(C11, NOP, 0, 0, 0, 0, 16'h0,           0, 0, 8'h05, 16'h0005, 0, 8'hA3, 5'h02));
    vecs.push_back(v(C15, NOP, 0, 0, 0, 0, 16'h0,           0, 0, 8'h05, 16'h00C1, 0, 8'hA3, 5'h02));
    vecs.push_back(v(0, SUB, 0, 0, 0, 0, 16'h0,             0, 0, 8'h05, 16'h00C1, 0, 8'hA3, 5'h06));
    vecs.push_back(v(0, OR, 0, 0, 0, 0, 16'h0,              0, 0, 8'h05, 16'h00C1, 0, 8'hA3, 5'h00));
    vecs.push_back(v(C5, NOP, 0, 0, 0, 0, 16'h0,            1, 0, 8'h05, 16'h00C1, 1, 8'hA3, 5'h00));
    vecs.push_back(v(0, NOP, 0, 0, 0, 1, 16'h00FF,          0, 0, 8'h05, 16'h00FF, 0, 8'hA3, 5'h00));
    vecs.push_back(v(C8, NOP, 0, 0, 0, 0, 16'h0,            0, 0, 8'hFF, 16'h00FF, 0, 8'hA3, 5'h00));
    vecs.push_back(v(0, NOP, 1, 0, 0, 0, 16'h0,             0, 0, 8'h00, 16'h00FF, 0, 8'hA3, 5'h00));
    vecs.push_back(v(C8, NOP, 1, 0, 0, 0, 16'h0,            0, 0, 8'hFF, 16'h00FF, 0, 8'hA3, 5'h00));
    vecs.push_back(v(C2, NOP, 1, 0, 0, 0, 16'h0,            0, 0, 8'h05, 16'h00FF, 0, 8'hA3, 5'h00));
    vecs.push_back(v(C8|C2, NOP, 0, 0, 0, 0, 16'h0,         0, 0, 8'hFF, 16'h00FF, 0, 8'hA3, 5'h00));
    vecs.push_back(v(C3, NOP, 0, 1, 0, 0, 16'h0,            0, 0, 8'hFF, 16'h00FF, 0, 8'hA3, 5'h00));
    vecs.push_back(v(0, NOP, 0, 1, 0, 0, 16'h0,             0, 0, 8'hFF, 16'h00FF, 0, 8'hA3, 5'h00));
    vecs.push_back(v(C1, NOP, 0, 0, 0, 0, 16'h0,            0, 0, 8'hFF, 16'h0000, 0, 8'hA3, 5'h00));
    vecs.push_back(v(C12|C1|C15, NOP, 0, 0, 0, 0, 16'h0,    0, 0, 8'hFF, 16'h0005, 0, 8'hA3, 5'h00));
    vecs.push_back(v(C1|C15, NOP, 0, 0, 0, 0, 16'h0,        0, 0, 8'hFF, 16'h0000, 0, 8'hA3, 5'h00));

    rst_n = 1'b0;
    drive(0, NOP, 0, 0, 0, 1, 16'hFFFF);
    #12;
    expect_out("reset_state", 0, 0, 8'h00, 16'h0000, 0, 8'h00, 5'h00);
    drive(0, NOP, 0, 0, 0, 0, 16'h0);
    #8;
    rst_n = 1'b1;

    for (int i = 0; i < vecs.size(); i++) begin
      drive(vecs[i].ctrl, vecs[i].alu, vecs[i].mi, vecs[i].pi, vecs[i].halt, vecs[i].rdy, vecs[i].rdata);
      step();
      expect_out($sformatf("vec%0d", i), vecs[i].req, vecs[i].we, vecs[i].addr, vecs[i].wdata,
                 vecs[i].busy, vecs[i].ir, vecs[i].fl);
    end

    // C5+C13 together: read wins, then an explicit write of ACC with a busy-period control storm
    drive(C5|C13, NOP, 0, 0, 0, 0, 16'h0);
    step();
    expect_out("c5c13_read_only", 1, 0, 8'hFF, 16'h0000, 1, 8'hA3, 5'h00);
    drive(0, NOP, 0, 0, 0, 1, 16'hBEEF);
    step();
    expect_out("c5c13_read_done", 0, 0, 8'hFF, 16'hBEEF, 0, 8'hA3, 5'h00);
    drive(C12, NOP, 0, 0, 0, 0, 16'h0);
    step();
    expect_out("acc_to_mbr", 0, 0, 8'hFF, 16'h0005, 0, 8'hA3, 5'h00);
    drive(C13, NOP, 0, 0, 0, 0, 16'h0);
    step();
    expect_out("write_start", 1, 1, 8'hFF, 16'h0005, 1, 8'hA3, 5'h00);
    drive(C12|C1|C8|C2|C3|C11|C5, NOT, 1, 1, 0, 0, 16'h0);
    step();
    expect_out("write_busy_ignores_ctrl", 1, 1, 8'hFF, 16'h0005, 1, 8'hA3, 5'h00);
    drive(0, NOP, 0, 0, 0, 1, 16'h1111);
    step();
    expect_out("write_done", 0, 0, 8'hFF, 16'h0005, 0, 8'hA3, 5'h00);
    drive(C1, NOP, 0, 0, 0, 0, 16'h0);
    step();
    expect_out("pc_untouched_by_busy", 0, 0, 8'hFF, 16'h0000, 0, 8'hA3, 5'h00);

    // Asynchronous reset in the middle of a read
    drive(0, NOP, 0, 1, 0, 0, 16'h0);
    step();
    drive(C5, NOP, 0, 0, 0, 0, 16'h0);
    step();
    expect_out("read_pending", 1, 0, 8'hFF, 16'h0000, 1, 8'hA3, 5'h00);
    #2;
    rst_n = 1'b0;
    #1;
    expect_out("async_reset_mid_read", 0, 0, 8'h00, 16'h0000, 0, 8'h00, 5'h00);
    drive(0, NOP, 0, 0, 0, 1, 16'hFFFF);
    #1;
    rst_n = 1'b1;
    step();
    expect_out("ready_after_reset_ignored", 0, 0, 8'h00, 16'h0000, 0, 8'h00, 5'h00);
    drive(C1, NOP, 0, 0, 0, 0, 16'h0);
    step();
    expect_out("pc_cleared", 0, 0, 8'h00, 16'h0000, 0, 8'h00, 5'h00);
    drive(C12, NOP, 0, 0, 0, 0, 16'h0);
    step();
    expect_out("acc_cleared", 0, 0, 8'h00, 16'h0000, 0, 8'h00, 5'h00);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/datapath_hs.md
# datapath_hs

Parametrised accumulator datapath (PC, MAR, MBR, IR, ACC, ALU with BR/MR) for the CPU, driven by the control unit's C0–C15 transfer word. It extends the fixed 16/8-bit register top with width parameters, an 8-way ALU with a double-width multiply, and a req/ready memory handshake that stalls the control unit through `o_busy`. It sits between the control unit and the external bus.

## Interface
- `DATA_W`, 16, data/MBR/ACC/IR width (≥ ADDR_W+OPC_W)
- `ADDR_W`, 8, PC/MAR width
- `OPC_W`, 8, opcode field width: IR[DATA_W-1 -: OPC_W]
- `i_clk` in 1: the single clock, rising edge.
- `i_rst_n` in 1: asynchronous, active-low reset.
- `i_ctrl` in 16: C0..C15 transfer enables (bit k = Ck)
- `i_alu_op` in 4: [3] ALU enable, [2:0] op
- `i_ctrl_mar_increment` in 1: MAR += 1
- `i_ctrl_pc_increment` in 1: PC += 1
- `i_ctrl_halt` in 1: force `o_ir_cu` to 0
- `o_mem_req` out 1: memory request, held until ready
- `o_mem_we` out 1: 1 = write, valid with req
- `o_mem_addr` out ADDR_W: MAR value
- `o_mem_wdata` out DATA_W: MBR value
- `i_mem_rdata` in DATA_W: read data, sampled with ready
- `i_mem_ready` in 1: transaction completes this edge
- `o_busy` out 1: memory FSM not IDLE, CU must hold
- `o_ir_cu` out OPC_W: latched opcode to CU
- `o_flags` out 5: {M,V,C,N,Z}

## Operation
- Reset: all registers, `o_ir_cu`, `o_flags` = 0; FSM IDLE; `o_mem_req`/`o_mem_we`/`o_busy` = 0.
- Transfers load on the rising edge and use pre-edge source values.
  - C1 PC→MBR, zero-extended.
  - C2 PC→MAR.
  - C3 MBR[ADDR_W-1:0]→PC.
  - C4 MBR→IR.
  - C8 MBR[ADDR_W-1:0]→MAR.
  - C9 BR→ACC.
  - C10 MR→ACC.
  - C11 MBR→ACC.
  - C12 ACC→MBR.
  - C14 IR opcode→`o_ir_cu` latch.
  - C15 IR[ADDR_W-1:0]→MBR, zero-extended.
  - C6 and C7 are ALU operand selects: Q=MBR, P=ACC, always routed; the bits are accepted and ignored.
- Destination priority on conflict:
  - MBR: memory read completion > C12 > C1 > C15.
  - ACC: C11 > C10 > C9.
  - MAR: C8 > C2 > increment.
  - PC: C3 > increment.
- Increments wrap modulo 2^ADDR_W.
- Memory FSM, states IDLE, READ, WRITE.
  - IDLE + C5 → READ.
  - IDLE + C13 (without C5) → WRITE.
  - C5 and C13 together → READ; the write is dropped.
  - C0 has no effect; the address is always MAR.
- READ/WRITE behaviour:
  - `o_mem_req` = 1.
  - `o_mem_we` = 1 in WRITE only.
  - On an edge with `i_mem_ready` = 1, READ loads MBR ← `i_mem_rdata`, then → IDLE.
  - While not IDLE, `i_ctrl`, `i_alu_op`, and both increments are ignored, so MAR and MBR stay stable.
- ALU, when `i_alu_op[3]` = 1, registers BR (low DATA_W), MR, and flags at the edge.
  - Ops: 000 ADD, 001 SUB (P-Q), 010 AND, 011 OR, 100 MUL unsigned (MR = high half), 101 NOT P, 110 SHL1, 111 SHR1 logical.
  - MR = 0 for every op except MUL.
  - Z = BR==0; N = BR msb.
  - C: carry out (ADD); borrow (SUB); shifted-out bit (SHL/SHR); 0 otherwise.
  - V: signed overflow for ADD/SUB, else 0.
  - M: MUL high half ≠ 0, else 0.
  - With enable = 0, BR, MR and flags hold.
- `o_ir_cu` = `i_ctrl_halt` ? 0 : latch. This is combinational on halt; the latch itself is unaffected.

## Timing
- `o_busy` = (state ≠ IDLE), registered state, no combinational path from `i_ctrl`.
- Read:
  - C5 sampled at edge T.
  - `o_mem_req` high from T.
  - First ready at edge T+k (k ≥ 1) loads MBR.
  - `o_busy` low after T+k.
  - Minimum read latency is 1 cycle, with `i_mem_ready` tied high.
- `i_mem_ready` is ignored in IDLE.
- ALU result in BR/MR one edge after the op; C9/C10 may follow on the very next cycle.
- `i_rst_n` low mid-transaction drops `o_mem_req` and `o_busy` asynchronously; the pending read never writes MBR.

## Test plan
- Reset with req asserted mid-READ → `o_mem_req`, `o_busy`, ACC, PC = 0 immediately; after release, `i_mem_ready`=1 changes nothing.
- PC=0x05, C2 then C5, memory returns 0xA3C1 with 3 wait cycles → `o_busy` high 4 cycles; MBR=0xA3C1; C4,C14 → `o_ir_cu`=0xA3; with halt=1 → 0x00.
- ACC=0x7FFF, MBR=0x0001, op ADD → BR=0x8000, flags V=1, N=1, Z=0, C=0; C9 → ACC=0x8000.
- ACC=0x1234, MBR=0x0100, MUL → BR=0x3400, MR=0x0012, M=1; C10 → ACC=0x0012.
- MAR=0xFF, increment → 0x00. C8 + increment in the same cycle → MBR low byte wins.
- C5+C13 together with ACC in MBR → read only (`o_mem_we`=0). Then C12,C13 → write with `o_mem_wdata`=ACC; `i_ctrl` asserted during busy has no effect.
